// File: rtl/gcn_addr_pkg.sv
// rtl/gcn_addr_pkg.sv - shared types and constants for the GCN operand address generator
package gcn_addr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD_WEIGHT,
    RD_FEATURE,
    FINISH
  } addr_gen_state_t;

  localparam logic SEL_WEIGHT  = 1'b0;
  localparam logic SEL_FEATURE = 1'b1;

endpackage

// File: rtl/gcn_wrap_counter.sv
// rtl/gcn_wrap_counter.sv - modulo-MAX counter with clear priority and terminal flag
module gcn_wrap_counter #(
  parameter int MAX   = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             at_max
);

  localparam logic [WIDTH-1:0] TOP = WIDTH'(MAX - 1);

  assign at_max = (count == TOP);

  // Wrap at TOP explicitly so non-power-of-two sizes never overshoot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= at_max ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/gcn_operand_addr_gen.sv
// rtl/gcn_operand_addr_gen.sv - weight-column / feature-row read address sequencer
import gcn_addr_pkg::*;

module gcn_operand_addr_gen #(
  parameter int FEATURE_ROWS   = 6,
  parameter int WEIGHT_COLS    = 3,
  parameter int ADDRESS_WIDTH  = 13,
  parameter int FEATURE_BASE   = 512,
  parameter int FEATURE_STRIDE = 1,
  parameter int WEIGHT_BASE    = 0,
  parameter int WEIGHT_STRIDE  = 1,
  parameter int ROW_W = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1,
  parameter int COL_W = (WEIGHT_COLS > 1) ? $clog2(WEIGHT_COLS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [ADDRESS_WIDTH-1:0] rd_addr,
  output logic                     rd_sel,
  output logic [ROW_W-1:0]         feature_count,
  output logic [COL_W-1:0]         weight_count,
  output logic                     last,
  output logic                     busy,
  output logic                     done
);

  localparam longint ADDR_SPAN   = longint'(1) << ADDRESS_WIDTH;
  localparam longint FEATURE_TOP = longint'(FEATURE_BASE) +
                                   longint'(FEATURE_ROWS - 1) * longint'(FEATURE_STRIDE);
  localparam longint WEIGHT_TOP  = longint'(WEIGHT_BASE) +
                                   longint'(WEIGHT_COLS - 1) * longint'(WEIGHT_STRIDE);

  if (FEATURE_TOP >= ADDR_SPAN) begin : g_feature_range_bad
    $error("feature address range exceeds ADDRESS_WIDTH");
  end
  if (WEIGHT_TOP >= ADDR_SPAN) begin : g_weight_range_bad
    $error("weight address range exceeds ADDRESS_WIDTH");
  end

  addr_gen_state_t state, state_next;
  logic row_inc, row_clr, row_at_max;
  logic col_inc, col_clr, col_at_max;
  logic fire;

  gcn_wrap_counter #(.MAX(FEATURE_ROWS), .WIDTH(ROW_W)) u_row_counter (
    .clk    (clk),
    .reset  (reset),
    .inc    (row_inc),
    .clr    (row_clr),
    .count  (feature_count),
    .at_max (row_at_max)
  );

  gcn_wrap_counter #(.MAX(WEIGHT_COLS), .WIDTH(COL_W)) u_col_counter (
    .clk    (clk),
    .reset  (reset),
    .inc    (col_inc),
    .clr    (col_clr),
    .count  (weight_count),
    .at_max (col_at_max)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  assign fire = rd_valid & rd_ready;

  // Abort wins over any handshake in the same cycle; the accepted beat is dropped.
  always_comb begin
    state_next = state;
    row_inc    = 1'b0;
    row_clr    = 1'b0;
    col_inc    = 1'b0;
    col_clr    = 1'b0;
    if (abort && state != IDLE) begin
      state_next = IDLE;
      row_clr    = 1'b1;
      col_clr    = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_next = RD_WEIGHT;
            row_clr    = 1'b1;
            col_clr    = 1'b1;
          end
        end
        RD_WEIGHT: begin
          if (fire) begin
            state_next = RD_FEATURE;
            row_clr    = 1'b1;
          end
        end
        RD_FEATURE: begin
          if (fire) begin
            if (!row_at_max) begin
              row_inc = 1'b1;
            end else if (!col_at_max) begin
              row_clr    = 1'b1;
              col_inc    = 1'b1;
              state_next = RD_WEIGHT;
            end else begin
              state_next = FINISH;
            end
          end
        end
        FINISH:  state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Everything below decodes registered state and counts only; rd_ready never reaches it.
  assign rd_valid = (state == RD_WEIGHT) || (state == RD_FEATURE);
  assign rd_sel   = (state == RD_FEATURE) ? SEL_FEATURE : SEL_WEIGHT;
  assign busy     = (state != IDLE);
  assign done     = (state == FINISH);
  assign last     = (state == RD_FEATURE) && row_at_max && col_at_max;

  always_comb begin
    rd_addr = '0;
    case (state)
      RD_WEIGHT: rd_addr = ADDRESS_WIDTH'(WEIGHT_BASE) +
                           ADDRESS_WIDTH'(weight_count) * ADDRESS_WIDTH'(WEIGHT_STRIDE);
      RD_FEATURE: rd_addr = ADDRESS_WIDTH'(FEATURE_BASE) +
                            ADDRESS_WIDTH'(feature_count) * ADDRESS_WIDTH'(FEATURE_STRIDE);
      default: rd_addr = '0;
    endcase
  end

endmodule

// File: tb/tb_gcn_operand_addr_gen.sv
// tb/tb_gcn_operand_addr_gen.sv - directed self-checking bench for gcn_operand_addr_gen
module tb_gcn_operand_addr_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        rd_ready = 1'b1;

  logic        rd_valid, rd_sel, last, busy, done;
  logic [12:0] rd_addr;
  logic [2:0]  feature_count;
  logic [1:0]  weight_count;

  logic        rd_valid1, rd_sel1, last1, busy1, done1;
  logic [12:0] rd_addr1;
  logic [0:0]  feature_count1;
  logic [0:0]  weight_count1;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  gcn_operand_addr_gen dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_sel(rd_sel),
    .feature_count(feature_count), .weight_count(weight_count),
    .last(last), .busy(busy), .done(done)
  );

  gcn_operand_addr_gen #(
    .FEATURE_ROWS(1), .WEIGHT_COLS(1), .FEATURE_BASE(100), .FEATURE_STRIDE(8)
  ) dut1 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .rd_valid(rd_valid1), .rd_ready(rd_ready), .rd_addr(rd_addr1), .rd_sel(rd_sel1),
    .feature_count(feature_count1), .weight_count(weight_count1),
    .last(last1), .busy(busy1), .done(done1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Request i of a default pass: each column is one weight beat then six feature beats.
  function automatic int exp_addr(input int i);
    int r;
    r = i % 7;
    return (r == 0) ? i / 7 : 512 + r - 1;
  endfunction

  task automatic start_pass();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic drain();
    rd_ready = 1'b1;
    for (int k = 0; k < 100 && !done; k++) step();
    check("drain_done", done, 1);
    step();
  endtask

  task automatic run_full_pass(input string tag);
    int busy_cycles;
    int bad;
    busy_cycles = 0;
    bad = 0;
    rd_ready = 1'b1;
    start_pass();
    for (int i = 0; i < 21; i++) begin
      int r;
      r = i % 7;
      if (busy) busy_cycles++;
      check({tag, "_valid"}, rd_valid, 1);
      check({tag, "_addr"}, rd_addr, exp_addr(i));
      check({tag, "_sel"}, rd_sel, (r != 0));
      check({tag, "_last"}, last, (i == 20));
      check({tag, "_fcount"}, feature_count, (r == 0) ? 0 : r - 1);
      check({tag, "_wcount"}, weight_count, i / 7);
      step();
    end
    if (busy) busy_cycles++;
    check({tag, "_done"}, done, 1);
    check({tag, "_finish_valid"}, rd_valid, 0);
    step();
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_busy_cycles"}, busy_cycles, 22);
    check({tag, "_hold_fcount"}, feature_count, 5);
    check({tag, "_hold_wcount"}, weight_count, 2);
  endtask

  initial begin
    int idx, cycles, done_cnt, invalid_seen;
    logic        p_valid, p_sel, p_last;
    logic [12:0] p_addr;
    logic [2:0]  p_fc;
    logic [1:0]  p_wc;

    // reset state
    step();
    step();
    check("rst_valid", rd_valid, 0);
    check("rst_addr", rd_addr, 0);
    check("rst_sel", rd_sel, 0);
    check("rst_fcount", feature_count, 0);
    check("rst_wcount", weight_count, 0);
    check("rst_last", last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b0;
    step();

    abort = 1'b1;
    step();
    abort = 1'b0;
    check("idle_abort_busy", busy, 0);

    run_full_pass("pass");

    // random stalls
    rd_ready = 1'b1;
    start_pass();
    idx = 0;
    cycles = 0;
    while (!done && cycles < 600) begin
      rd_ready = 1'($urandom_range(0, 1));
      p_valid = rd_valid; p_addr = rd_addr; p_sel = rd_sel;
      p_fc = feature_count; p_wc = weight_count; p_last = last;
      step();
      cycles++;
      if (p_valid && rd_ready) begin
        check("stall_accept_addr", p_addr, exp_addr(idx));
        check("stall_accept_sel", p_sel, ((idx % 7) != 0));
        check("stall_accept_last", p_last, (idx == 20));
        idx++;
      end else if (p_valid) begin
        check("stall_hold_valid", rd_valid, 1);
        check("stall_hold_addr", rd_addr, p_addr);
        check("stall_hold_sel", rd_sel, p_sel);
        check("stall_hold_fcount", feature_count, p_fc);
        check("stall_hold_wcount", weight_count, p_wc);
        check("stall_hold_last", last, p_last);
      end
    end
    check("stall_count", idx, 21);
    check("stall_done", done, 1);
    rd_ready = 1'b1;
    step();

    // abort at third feature beat of column 1
    start_pass();
    repeat (10) step();
    check("abort_pre_addr", rd_addr, 514);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_valid", rd_valid, 0);
    check("abort_fcount", feature_count, 0);
    check("abort_wcount", weight_count, 0);
    check("abort_done", done, 0);
    step();
    check("abort_no_done", done, 0);
    start_pass();
    check("restart_valid", rd_valid, 1);
    check("restart_addr", rd_addr, 0);
    check("restart_sel", rd_sel, 0);
    drain();

    // start held through the pass and the FINISH cycle
    done_cnt = 0;
    invalid_seen = 0;
    start = 1'b1;
    step();
    repeat (21) begin
      step();
      if (done) done_cnt++;
    end
    check("held_finish_done", done, 1);
    step();
    check("held_finish_ignored", busy, 0);
    start = 1'b0;
    repeat (5) begin
      step();
      if (rd_valid) invalid_seen++;
      if (done) done_cnt++;
    end
    check("held_no_second_pass", invalid_seen, 0);
    check("held_done_pulses", done_cnt, 1);
    start_pass();
    check("held_second_valid", rd_valid, 1);
    check("held_second_addr", rd_addr, 0);
    drain();

    // 1x1 configuration
    start_pass();
    check("one_w_valid", rd_valid1, 1);
    check("one_w_addr", rd_addr1, 0);
    check("one_w_sel", rd_sel1, 0);
    check("one_w_last", last1, 0);
    step();
    check("one_f_valid", rd_valid1, 1);
    check("one_f_addr", rd_addr1, 100);
    check("one_f_sel", rd_sel1, 1);
    check("one_f_last", last1, 1);
    step();
    check("one_done", done1, 1);
    check("one_done_valid", rd_valid1, 0);
    step();
    check("one_idle", busy1, 0);
    drain();

    // asynchronous reset mid RD_FEATURE
    start_pass();
    repeat (3) step();
    check("areset_pre_sel", rd_sel, 1);
    #2 reset = 1'b1;
    #1;
    check("areset_valid", rd_valid, 0);
    check("areset_addr", rd_addr, 0);
    check("areset_sel", rd_sel, 0);
    check("areset_fcount", feature_count, 0);
    check("areset_wcount", weight_count, 0);
    check("areset_last", last, 0);
    check("areset_busy", busy, 0);
    check("areset_done", done, 0);
    step();
    reset = 1'b0;
    step();
    run_full_pass("post_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gcn_operand_addr_gen.md
Name: gcn_operand_addr_gen

Overview:
- Parametrised read-address sequencer for the GCN combination stage (feature matrix × weight matrix).
- Walks every weight column. For each column it issues one weight-column read, then one read per feature row.
- Address/select pairs leave through a valid/ready handshake to the memory read arbiter.
- Also emits the (row, col) index of the product element being formed, so the downstream multiply/scratch-pad writer can place results.

Parameters:
- FEATURE_ROWS, 6: feature rows per pass (≥1).
- WEIGHT_COLS, 3: weight columns per pass (≥1).
- ADDRESS_WIDTH, 13: read address width.
- FEATURE_BASE, 512: address of feature row 0.
- FEATURE_STRIDE, 1: address increment between consecutive feature rows (≥1).
- WEIGHT_BASE, 0: address of weight column 0.
- WEIGHT_STRIDE, 1: address increment between weight columns (≥1).
- ROW_W, $clog2(FEATURE_ROWS) min 1: row counter width.
- COL_W, $clog2(WEIGHT_COLS) min 1: column counter width.

Ports:
- clk, input, 1: clock.
- reset, input, 1: asynchronous active-high reset.
- start, input, 1: begin a pass. Honoured only in IDLE.
- abort, input, 1: synchronous cancel of the current pass.
- rd_valid, output, 1: rd_addr/rd_sel hold a request.
- rd_ready, input, 1: arbiter accepts the request this cycle.
- rd_addr, output, ADDRESS_WIDTH: read address.
- rd_sel, output, 1: 1 = feature memory, 0 = weight memory.
- feature_count, output, ROW_W: current feature row.
- weight_count, output, COL_W: current weight column.
- last, output, 1: current request is the final one of the pass.
- busy, output, 1: pass in progress.
- done, output, 1: one-cycle pulse when the pass completes.

Behaviour:
- Reset values: state=IDLE. All outputs 0: rd_valid, rd_addr, rd_sel, feature_count, weight_count, last, busy, done.
- States: IDLE, RD_WEIGHT, RD_FEATURE, FINISH.
- Handshake: a request is consumed on rd_valid && rd_ready.
  - While rd_valid=1 and rd_ready=0, rd_addr, rd_sel, the counts and last hold stable.
  - Counters change only on a consumed request.
- IDLE:
  - rd_valid=0, busy=0.
  - start=1 → RD_WEIGHT next cycle, with counts cleared to 0.
- RD_WEIGHT:
  - rd_valid=1, rd_sel=0, rd_addr = WEIGHT_BASE + weight_count*WEIGHT_STRIDE.
  - On handshake → RD_FEATURE with feature_count=0.
- RD_FEATURE:
  - rd_valid=1, rd_sel=1, rd_addr = FEATURE_BASE + feature_count*FEATURE_STRIDE.
  - On handshake, if feature_count < FEATURE_ROWS-1: feature_count+1, stay in RD_FEATURE.
  - On handshake at the last row:
    - if weight_count < WEIGHT_COLS-1: weight_count+1, feature_count=0 → RD_WEIGHT;
    - otherwise → FINISH.
- FINISH:
  - rd_valid=0, done=1 for exactly one cycle → IDLE.
  - Counts hold their final values until the next start.
- busy=1 in RD_WEIGHT, RD_FEATURE and FINISH.
- last=1 only in RD_FEATURE with feature_count=FEATURE_ROWS-1 and weight_count=WEIGHT_COLS-1.
- Outputs are registered or decoded from registered state only. There is no combinational path from rd_ready to rd_valid or rd_addr.
- Latency:
  - First request is valid one cycle after start.
  - With rd_ready tied high, a pass takes WEIGHT_COLS*(FEATURE_ROWS+1) request cycles, plus one FINISH cycle.
- Address arithmetic:
  - Computed at ADDRESS_WIDTH and truncated modulo 2^ADDRESS_WIDTH.
  - Elaboration-time assertion: FEATURE_BASE + (FEATURE_ROWS-1)*FEATURE_STRIDE < 2^ADDRESS_WIDTH.
  - Same assertion for the weight range.
- Counter wrap: counters never exceed ROWS-1 / COLS-1. Non-power-of-two sizes wrap explicitly at the terminal value.
- Boundary conditions:
  - start while busy: ignored.
  - start coincident with the FINISH cycle: ignored; a new start is required in IDLE.
  - abort: highest priority after reset. From any non-IDLE state → IDLE next cycle, counts cleared, no done pulse. Applies even if a handshake occurs that cycle; that request counts as accepted but is discarded.
  - abort in IDLE: no effect.
  - Asynchronous reset mid-pass: immediate return to reset values; no done.
  - FEATURE_ROWS=1 or WEIGHT_COLS=1 must work: RD_FEATURE is a single beat, and last asserts on the first feature request of the final column.

Decomposition:
- Package gcn_addr_pkg holds:
  - state enum addr_gen_state_t {IDLE, RD_WEIGHT, RD_FEATURE, FINISH};
  - localparams SEL_WEIGHT=1'b0, SEL_FEATURE=1'b1.
- One sub-module: gcn_wrap_counter.
  - Parameters: MAX, WIDTH.
  - Ports: inc, clr, count, at_max.
  - Instantiated twice, once for rows and once for columns.
- The FSM and address multiply-add stay in the top.

Test Plan:
- Defaults, rd_ready=1, start pulse:
  - rd_addr sequence 0, 512..517, 1, 512..517, 2, 512..517;
  - rd_sel 0,1×6 repeating;
  - last only on the 21st request;
  - done one cycle after it;
  - 22 cycles busy in total.
- Random rd_ready stalls (~50%): addr/sel/counts stable across every stalled cycle; the accepted-address stream equals the no-stall sequence.
- abort asserted at the 3rd feature request of column 1: IDLE next cycle, counts=0, no done. A following start replays from address 0.
- start held high through a pass and through FINISH: exactly one pass, one done pulse. A second pass begins only after a start seen in IDLE.
- FEATURE_ROWS=1, WEIGHT_COLS=1, FEATURE_BASE=100, FEATURE_STRIDE=8: requests 0(sel 0), 100(sel 1, last=1), then done.
- Async reset asserted mid-RD_FEATURE between clock edges: all outputs 0 immediately. After release, start produces a full correct pass.
